// File: rtl/forward_ctrl.sv
// EX-stage operand forwarding select and load-use stall detection for a 5-stage pipeline.
// Optional saturating statistics counters are enabled by defining FWD_STATS_EN.
module forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      fwd_count,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // Only the EX and MEM slots are ever consulted: the sel is latched as the
  // instruction enters EX, so the MEM slot is what becomes MEM/WB. A load's
  // mem_read flag is irrelevant once it has left EX.
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q;
  logic                  ex_rw_q, ex_rw_d, mem_rw_q;
  logic                  ex_mr_q, ex_mr_d;
  logic [1:0]            sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic                  id_bubble;

  function automatic logic [1:0] src_sel(
    input logic [REG_ADDR_W-1:0] s,
    input logic                  ex_rw,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  mem_rw,
    input logic [REG_ADDR_W-1:0] mem_rd
  );
    logic [1:0] r;
    r = SEL_RF;
    if (s != ZR) begin
      if (ex_rw && (ex_rd == s))        r = SEL_MEM;
      else if (mem_rw && (mem_rd == s)) r = SEL_WB;
    end
    return r;
  endfunction

  always_comb begin
    stall = id_valid && ex_mr_q && ex_rw_q && (ex_rd_q != ZR) &&
            ((ex_rd_q == id_rn) || (ex_rd_q == id_rm));
    id_bubble = !id_valid || stall || flush;
    ex_rd_d = ZR;
    ex_rw_d = 1'b0;
    ex_mr_d = 1'b0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!id_bubble) begin
      ex_rd_d = id_rd;
      ex_rw_d = id_reg_write;
      ex_mr_d = id_mem_read;
      sel_a_d = src_sel(id_rn, ex_rw_q, ex_rd_q, mem_rw_q, mem_rd_q);
      sel_b_d = src_sel(id_rm, ex_rw_q, ex_rd_q, mem_rw_q, mem_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_q  <= ZR;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= ZR;
      mem_rw_q <= 1'b0;
      sel_a_q  <= SEL_RF;
      sel_b_q  <= SEL_RF;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= ex_rd_q;
      mem_rw_q <= ex_rw_q;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [1:0]       fwd_inc;
  logic [CNT_W:0]   fwd_sum, stall_sum;

  // Extra top bit catches the carry so the counters stick at all-ones.
  always_comb begin
    fwd_inc     = {1'b0, (sel_a_d != SEL_RF)} + {1'b0, (sel_b_d != SEL_RF)};
    fwd_sum     = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_inc};
    stall_sum   = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, stall};
    fwd_cnt_d   = fwd_sum[CNT_W]   ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
    stall_cnt_d = stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_count   = fwd_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fwd_count   = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed and random checks of forward_ctrl against a history-based reference model.
module tb_forward_ctrl;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_reg_write, id_mem_read, flush;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_count, stall_count;

  forward_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_count(fwd_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  localparam ins_t BUBBLE = '{rd: 5'd31, rw: 1'b0, mr: 1'b0};

  // hist[0] is the instruction that entered EX most recently, hist[1] the one before.
  ins_t        hist[$];
  int unsigned m_fwd, m_stall;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest producer of s among the two older in-flight instructions wins.
  function automatic logic [1:0] ref_sel(input logic [4:0] s);
    if (s == 5'd31) return 2'b00;
    for (int k = 0; k < 2 && k < hist.size(); k++)
      if (hist[k].rw && hist[k].rd == s) return (k == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_fwd_cnt();
`ifdef FWD_STATS_EN
    return m_fwd;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_stall_cnt();
`ifdef FWD_STATS_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1; id_valid = 1'b0; flush = 1'b0;
    id_rn = 5'd0; id_rm = 5'd0; id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    hist = {BUBBLE, BUBBLE};
    m_fwd = 0; m_stall = 0;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_sel_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("rst_sel_b", {30'd0, fwd_b_sel}, 32'd0);
    chk("rst_fwd_cnt", fwd_count, 32'd0);
    chk("rst_stall_cnt", stall_count, 32'd0);
    reset = 1'b0;
  endtask

  task automatic step(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    logic       e_stall, bub;
    logic [1:0] e_a, e_b;
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
    e_stall = v && hist[0].mr && hist[0].rw && hist[0].rd != 5'd31 &&
              (hist[0].rd == rn || hist[0].rd == rm);
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    bub = !v || e_stall || fl;
    e_a = bub ? 2'b00 : ref_sel(rn);
    e_b = bub ? 2'b00 : ref_sel(rm);
    @(posedge clk);
    #1;
    hist.push_front(bub ? BUBBLE : '{rd: rd, rw: rw, mr: mr});
    if (hist.size() > 2) void'(hist.pop_back());
    m_fwd   += (e_a != 2'b00) + (e_b != 2'b00);
    m_stall += e_stall;
    chk("sel_a", {30'd0, fwd_a_sel}, {30'd0, e_a});
    chk("sel_b", {30'd0, fwd_b_sel}, {30'd0, e_b});
    chk("fwd_cnt", fwd_count, exp_fwd_cnt());
    chk("stall_cnt", stall_count, exp_stall_cnt());
  endtask

  initial begin
    do_reset(2);

    // ADD X1,X2,X3 ; ADD X2,X1,X3
    step(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    step(1, 5'd1, 5'd3, 5'd2, 1, 0, 0);
    chk("b2b_a_lit", {30'd0, fwd_a_sel}, 32'd1);
    chk("b2b_b_lit", {30'd0, fwd_b_sel}, 32'd0);

    // ADD X1 ; unrelated ; SUB X4,X5,X1
    step(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    step(1, 5'd7, 5'd8, 5'd6, 1, 0, 0);
    step(1, 5'd5, 5'd1, 5'd4, 1, 0, 0);
    chk("dist2_b_lit", {30'd0, fwd_b_sel}, 32'd2);

    // ADD X1 ; ADD X1 ; user: newest wins
    step(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    step(1, 5'd4, 5'd5, 5'd1, 1, 0, 0);
    step(1, 5'd1, 5'd1, 5'd9, 1, 0, 0);
    chk("newest_a_lit", {30'd0, fwd_a_sel}, 32'd1);

    // LDUR X1 ; ADD X2,X1,X1 (stall once, then retry gets 10/10)
    do_reset(1);
    step(1, 5'd2, 5'd31, 5'd1, 1, 1, 0);
    step(1, 5'd1, 5'd1, 5'd2, 1, 0, 0);
    step(1, 5'd1, 5'd1, 5'd2, 1, 0, 0);
    chk("lu_a_lit", {30'd0, fwd_a_sel}, 32'd2);
    chk("lu_b_lit", {30'd0, fwd_b_sel}, 32'd2);
`ifdef FWD_STATS_EN
    chk("lu_stall_cnt_lit", stall_count, 32'd1);
    chk("lu_fwd_cnt_lit", fwd_count, 32'd2);
`endif

    // X31 writer then X31 reader
    step(1, 5'd2, 5'd3, 5'd31, 1, 0, 0);
    step(1, 5'd31, 5'd31, 5'd4, 1, 0, 0);
    chk("xzr_a_lit", {30'd0, fwd_a_sel}, 32'd0);

    // Flushed load must not cause a stall on the following user
    step(1, 5'd2, 5'd31, 5'd6, 1, 1, 1);
    step(1, 5'd6, 5'd6, 5'd7, 1, 0, 0);
    chk("flush_nostall_a_lit", {30'd0, fwd_a_sel}, 32'd0);

    // Load two ahead of its user: no stall, sel 10
    step(1, 5'd2, 5'd31, 5'd10, 1, 1, 0);
    step(1, 5'd3, 5'd4, 5'd11, 1, 0, 0);
    step(1, 5'd10, 5'd3, 5'd12, 1, 0, 0);
    chk("ld_dist2_a_lit", {30'd0, fwd_a_sel}, 32'd2);

    // Mid-stream reset discards in-flight producers
    step(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    do_reset(1);
    step(1, 5'd1, 5'd1, 5'd5, 1, 0, 0);
    chk("midrst_a_lit", {30'd0, fwd_a_sel}, 32'd0);

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r[3];
      for (int j = 0; j < 3; j++)
        r[j] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      step($urandom_range(0, 9) != 0, r[0], r[1], r[2],
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
